// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension execute unit.
// It computes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
// Multiplies use shift-add and divides use restoring radix-2.
// Each operation takes one bit per cycle over XLEN RUN cycles, then one DONE cycle.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-low reset
//   start   launch request, sampled only in IDLE
//   op      funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   srca    rs1 operand (captured at start)
//   srcb    rs2 operand (captured at start)
//   flush   abort the current operation; also blocks a launch from IDLE
//   busy    high in RUN and DONE
//   done    one-cycle pulse; result is valid in the same cycle
//   result  operation result, held until the next completed operation
module muldiv_unit #(
  parameter int unsigned XLEN      = 32,
  parameter bit          EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [2*XLEN-1:0] acc, acc_d;        // mul: {hi, multiplier}; div: {remainder, dividend/quotient}
  logic [XLEN-1:0]   opb, opb_d;        // multiplicand or divisor magnitude
  logic              neg_q, neg_d;
  logic              spec_q, spec_d;
  logic [XLEN-1:0]   spec_res_q, spec_res_d;
  logic [XLEN-1:0]   result_d;
  logic              busy_d, done_d;

  // Operand decode at launch: signedness, magnitudes and divide special cases.
  logic            a_sgn_c, b_sgn_c, a_neg_c, b_neg_c;
  logic            div_zero_c, div_ovf_c, special_c;
  logic [XLEN-1:0] a_mag_c, b_mag_c, spec_val_c;

  assign a_sgn_c    = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
  assign b_sgn_c    = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
  assign a_neg_c    = a_sgn_c & srca[XLEN-1];
  assign b_neg_c    = b_sgn_c & srcb[XLEN-1];
  assign a_mag_c    = a_neg_c ? -srca : srca;
  assign b_mag_c    = b_neg_c ? -srcb : srcb;
  assign div_zero_c = op[2] && (srcb == '0);
  assign div_ovf_c  = op[2] && !op[0] && (srca == XMIN) && (srcb == '1);
  assign special_c  = div_zero_c | div_ovf_c;

  // Special-case value: x/0 = -1, x%0 = x; MIN/-1 = MIN, MIN%-1 = 0.
  always_comb begin
    spec_val_c = '0;
    if (div_zero_c) spec_val_c = op[1] ? srca : '1;
    else            spec_val_c = op[1] ? '0 : srca;
  end

  // One iteration of shift-add (mul) or restoring subtract (div).
  logic [XLEN:0]     add_sum, rem_sh, rem_diff;
  logic [2*XLEN-1:0] iter_acc;

  always_comb begin
    add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    rem_diff = rem_sh - {1'b0, opb};
    iter_acc = {add_sum, acc[XLEN-1:1]};
    if (op_q[2]) begin
      if (!rem_diff[XLEN]) iter_acc = {rem_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else                 iter_acc = {rem_sh[XLEN-1:0],   acc[XLEN-2:0], 1'b0};
    end
  end

  // Final result from the last iteration, with sign fix-up.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   div_pick, fin_val;

  always_comb begin
    prod     = neg_q ? -iter_acc : iter_acc;
    div_pick = op_q[1] ? iter_acc[2*XLEN-1:XLEN] : iter_acc[XLEN-1:0];
    fin_val  = '0;
    if (spec_q)                 fin_val = spec_res_q;
    else if (op_q[2])           fin_val = neg_q ? -div_pick : div_pick;
    else if (op_q[1:0] == 2'd0) fin_val = prod[XLEN-1:0];
    else                        fin_val = prod[2*XLEN-1:XLEN];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    op_d       = op_q;
    acc_d      = acc;
    opb_d      = opb;
    neg_d      = neg_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    result_d   = result;

    case (state)
      S_IDLE: begin
        if (start && !flush) begin
          op_d       = op;
          opb_d      = b_mag_c;
          acc_d      = {{XLEN{1'b0}}, a_mag_c};
          cnt_d      = CW'(XLEN - 1);
          neg_d      = (op[2] && op[1]) ? a_neg_c : (a_neg_c ^ b_neg_c);
          spec_d     = special_c;
          spec_res_d = spec_val_c;
          if (EARLY_OUT && special_c) begin
            state_d  = S_DONE;
            result_d = spec_val_c;
          end else begin
            state_d  = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = iter_acc;
          cnt_d = cnt - CW'(1);
          if (cnt == '0) begin
            state_d  = S_DONE;
            result_d = fin_val;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op_q       <= '0;
      acc        <= '0;
      opb        <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      result     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      op_q       <= op_d;
      acc        <= acc_d;
      opb        <= opb_d;
      neg_q      <= neg_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      result     <= result_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int XL = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    op;
  logic [XL-1:0] srca, srcb;
  logic          flush;
  logic          busy1, done1, busy0, done0;
  logic [XL-1:0] result1, result0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XL), .EARLY_OUT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .flush(flush), .busy(busy1), .done(done1), .result(result1)
  );

  muldiv_unit #(.XLEN(XL), .EARLY_OUT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .flush(flush), .busy(busy0), .done(done0), .result(result0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic plus the RISC-V divide rules.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint     sa, sb, ub;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ub = longint'({32'd0, b});
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
    return o[2] && ((b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Launch one op on both units and check latency, pulse width, busy and result.
  // extra_at > 0 pulses a second (ignored) start during that cycle.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int extra_at);
    int lat1, lat0, cnt1, cnt0, bbad1, bbad0, elat1;
    logic [31:0] res1, res0;
    elat1 = is_special(o, a, b) ? 1 : 33;
    lat1 = -1; lat0 = -1; cnt1 = 0; cnt0 = 0; bbad1 = 0; bbad0 = 0;
    res1 = 'x; res0 = 'x;
    @(negedge clk);
    start = 1'b1; op = o; srca = a; srcb = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); srca = $urandom; srcb = $urandom;
    for (int k = 1; k <= 40; k++) begin
      if (done1) begin if (lat1 < 0) lat1 = k; cnt1++; res1 = result1; end
      if (done0) begin if (lat0 < 0) lat0 = k; cnt0++; res0 = result0; end
      if (busy1 !== (k <= elat1)) bbad1++;
      if (busy0 !== (k <= 33)) bbad0++;
      start = (extra_at > 0 && k == extra_at);
      if (k < 40) begin @(posedge clk); #1; end
    end
    start = 1'b0;
    check({tag, " lat1"},  32'(lat1), 32'(elat1));
    check({tag, " lat0"},  32'(lat0), 32'd33);
    check({tag, " pulses1"}, 32'(cnt1), 32'd1);
    check({tag, " pulses0"}, 32'(cnt0), 32'd1);
    check({tag, " busy1 bad cycles"}, 32'(bbad1), 32'd0);
    check({tag, " busy0 bad cycles"}, 32'(bbad0), 32'd0);
    check({tag, " res1"}, res1, exp);
    check({tag, " res0"}, res0, exp);
    check({tag, " held1"}, result1, exp);
    check({tag, " held0"}, result0, exp);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb, prev;
    bit          seen_done;

    reset = 1'b0; start = 1'b0; op = 3'd0; srca = '0; srcb = '0; flush = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst busy1", 32'(busy1), 32'd0);
    check("rst done1", 32'(done1), 32'd0);
    check("rst result1", result1, 32'd0);
    check("rst busy0", 32'(busy0), 32'd0);
    check("rst result0", result0, 32'd0);
    @(negedge clk); reset = 1'b1;

    // Directed multiply / divide values
    run_op("MUL",    3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    run_op("MULH",   3'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    run_op("MULHU",  3'd3, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 0);
    run_op("DIV",    3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 0);
    run_op("REM",    3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 0);
    run_op("DIVU",   3'd5, 32'd100, 32'd7, 32'd14, 0);
    run_op("REMU",   3'd7, 32'd100, 32'd7, 32'd2, 0);
    run_op("DIV0",   3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("REM0",   3'd6, 32'd5, 32'd0, 32'd5, 0);
    run_op("DIVOVF", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("REMOVF", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

    // Randomised ops against the reference model
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom); ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op("RAND", ro, ra, rb, ref_model(ro, ra, rb), 0);
    end

    // flush dominates start in IDLE
    prev = result0;
    @(negedge clk); start = 1'b1; flush = 1'b1; op = 3'd0; srca = 32'd3; srcb = 32'd3;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    check("idle flush busy1", 32'(busy1), 32'd0);
    check("idle flush busy0", 32'(busy0), 32'd0);

    // flush mid-RUN: no done, result unchanged
    seen_done = 1'b0;
    @(negedge clk); start = 1'b1; op = 3'd0; srca = 32'd9; srcb = 32'd11;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 1; k < 10; k++) begin
      seen_done |= done0 | done1;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    seen_done |= done0 | done1;
    check("flush busy1", 32'(busy1), 32'd0);
    check("flush busy0", 32'(busy0), 32'd0);
    check("flush no done", 32'(seen_done), 32'd0);
    check("flush result0", result0, prev);
    check("flush result1", result1, prev);

    // Relaunch after flush, with an ignored start during RUN
    @(posedge clk); #1;
    run_op("RELAUNCH", 3'd0, 32'd9, 32'd11, 32'd99, 20);

    // Async reset mid-RUN
    @(negedge clk); start = 1'b1; op = 3'd3; srca = 32'hFFFF_FFFF; srcb = 32'hFFFF_FFFF;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1; reset = 1'b0; #1;
    check("midrst busy0", 32'(busy0), 32'd0);
    check("midrst done0", 32'(done0), 32'd0);
    check("midrst result0", result0, 32'd0);
    check("midrst result1", result1, 32'd0);
    @(negedge clk); reset = 1'b1;
    run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
